cache_ctrl_hs: RTL and testbench

Parametrised next-generation controller for the direct-mapped, write-through, one-word-block data cache. It sits between the core's load/store enables and the tag/data arrays.
- Replaces the fixed-latency read-miss sequence with a mem_ready handshake for both reads and writes.
- Adds an optional write-allocate mode, a memory timeout error and saturating hit/miss counters.

---
 rtl/cache_ctrl_hs.sv | 120 ++++++++++++
 tb/tb_cache_ctrl_hs.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_hs.sv
// cache_ctrl_hs: direct-mapped write-through cache controller with mem_ready handshake,
// optional write-allocate, wait-state timeout and saturating hit/miss counters.
module cache_ctrl_hs #(
    parameter bit WRITE_ALLOC = 1'b0,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_R,
    input  logic             en_W,
    input  logic             hit,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             Read_mem,
    output logic             Write_mem,
    output logic             Valid_enable,
    output logic             Tag_enable,
    output logic             Data_enable,
    output logic             sel_mem_core,
    output logic             stall,
    output logic             mem_err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_FILL, WR_WAIT} state_t;
    localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic mem_err_q, mem_err_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic timeout, hit_inc, miss_inc, arr_we;
    // the wait counter counts cycles already spent waiting, so the last allowed one is TIMEOUT-1
    assign timeout  = (TIMEOUT > 0) && !mem_ready && (wait_q == WAIT_LAST);
    assign hit_inc  = (state_q == IDLE) && (en_R || en_W) && hit;
    assign miss_inc = (state_q == IDLE) && (en_R || en_W) && !hit;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            mem_err_q  <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            mem_err_q  <= mem_err_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            IDLE: begin
                if (en_R && !hit) begin
                    state_d = RD_WAIT;
                    wait_d  = '0;
                end else if (!en_R && en_W && !mem_ready) begin
                    state_d = WR_WAIT;
                    wait_d  = '0;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ready) begin
                    state_d = (state_q == RD_WAIT) ? RD_FILL : IDLE;
                end else if (timeout) begin
                    state_d   = IDLE;
                    mem_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RD_FILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        hit_cnt_d  = cnt_clr ? '0 : (hit_inc && hit_cnt_q != CNT_MAX) ? hit_cnt_q + 1'b1 : hit_cnt_q;
        miss_cnt_d = cnt_clr ? '0 : (miss_inc && miss_cnt_q != CNT_MAX) ? miss_cnt_q + 1'b1 : miss_cnt_q;
    end
    always_comb begin
        Read_mem     = 1'b0;
        Write_mem    = 1'b0;
        arr_we       = 1'b0;
        sel_mem_core = 1'b0;
        stall        = 1'b0;
        unique case (state_q)
            IDLE: begin
                Read_mem     = en_R && !hit;
                Write_mem    = !en_R && en_W;
                arr_we       = Write_mem && (hit || WRITE_ALLOC);
                sel_mem_core = arr_we;
                stall        = en_R ? !hit : (en_W && !mem_ready);
            end
            RD_WAIT: begin
                Read_mem = 1'b1;
                stall    = 1'b1;
            end
            RD_FILL: begin
                Read_mem = 1'b1;
                arr_we   = 1'b1;
                stall    = 1'b1;
            end
            WR_WAIT: begin
                Write_mem = 1'b1;
                stall     = !mem_ready;
            end
            default: stall = 1'b0;
        endcase
    end
    assign Valid_enable = arr_we;
    assign Tag_enable   = arr_we;
    assign Data_enable  = arr_we;
    assign mem_err      = mem_err_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl_hs.sv
// tb_cache_ctrl_hs: directed table plus randomized run of two cache_ctrl_hs configurations
// against a transaction-level reference model.
module tb_cache_ctrl_hs;
    logic clk = 1'b0, rst = 1'b1;
    logic en_R = 1'b0, en_W = 1'b0, hit = 1'b0, mem_ready = 1'b0, cnt_clr = 1'b0;
    logic rd_a, wr_a, ve_a, te_a, de_a, sel_a, st_a, err_a;
    logic rd_b, wr_b, ve_b, te_b, de_b, sel_b, st_b, err_b;
    logic [3:0]  hc_a, mc_a;
    logic [15:0] hc_b, mc_b;
    logic [7:0]  out_a, out_b;
    int checks = 0, failures = 0;
    int ph[2], wt[2], hc[2], mc[2];
    logic err[2];
    bit WA[2] = '{1'b1, 1'b0};
    int TO[2] = '{8, 0};
    int MX[2] = '{15, 65535};
    typedef struct {
        logic r, w, h, m, c;
        logic [5:0] o;
        int hc, mc;
    } vec_t;
    vec_t tab[$];

    always #5 clk = ~clk;

    cache_ctrl_hs #(.WRITE_ALLOC(1'b1), .TIMEOUT(8), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .en_R(en_R), .en_W(en_W), .hit(hit), .mem_ready(mem_ready),
        .cnt_clr(cnt_clr), .Read_mem(rd_a), .Write_mem(wr_a), .Valid_enable(ve_a),
        .Tag_enable(te_a), .Data_enable(de_a), .sel_mem_core(sel_a), .stall(st_a),
        .mem_err(err_a), .hit_cnt(hc_a), .miss_cnt(mc_a));
    cache_ctrl_hs #(.WRITE_ALLOC(1'b0), .TIMEOUT(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .en_R(en_R), .en_W(en_W), .hit(hit), .mem_ready(mem_ready),
        .cnt_clr(cnt_clr), .Read_mem(rd_b), .Write_mem(wr_b), .Valid_enable(ve_b),
        .Tag_enable(te_b), .Data_enable(de_b), .sel_mem_core(sel_b), .stall(st_b),
        .mem_err(err_b), .hit_cnt(hc_b), .miss_cnt(mc_b));

    assign out_a = {rd_a, wr_a, ve_a, te_a, de_a, sel_a, st_a, err_a};
    assign out_b = {rd_b, wr_b, ve_b, te_b, de_b, sel_b, st_b, err_b};

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // phases: 0 idle, 1 waiting for read data, 2 refill cycle, 3 waiting for write ack
    function automatic logic [7:0] mout(input int i);
        logic rd, wr, en, sel, st;
        rd = 1'b0; wr = 1'b0; en = 1'b0; sel = 1'b0; st = 1'b0;
        if (ph[i] == 0) begin
            if (en_R) begin
                rd = !hit;
                st = !hit;
            end else if (en_W) begin
                wr  = 1'b1;
                en  = hit || WA[i];
                sel = en;
                st  = !mem_ready;
            end
        end else if (ph[i] == 1) begin
            rd = 1'b1; st = 1'b1;
        end else if (ph[i] == 2) begin
            rd = 1'b1; en = 1'b1; st = 1'b1;
        end else begin
            wr = 1'b1; st = !mem_ready;
        end
        return {rd, wr, en, en, en, sel, st, err[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; wt[i] = 0; hc[i] = 0; mc[i] = 0; err[i] = 1'b0;
        end
    endtask

    task automatic model_clk();
        for (int i = 0; i < 2; i++) begin
            if (ph[i] == 0) begin
                if (en_R || en_W) begin
                    if (hit) hc[i] = (hc[i] == MX[i]) ? hc[i] : hc[i] + 1;
                    else     mc[i] = (mc[i] == MX[i]) ? mc[i] : mc[i] + 1;
                end
                if (en_R && !hit) begin
                    ph[i] = 1; wt[i] = 0;
                end else if (!en_R && en_W && !mem_ready) begin
                    ph[i] = 3; wt[i] = 0;
                end
            end else if (ph[i] == 2) begin
                ph[i] = 0;
            end else if (mem_ready) begin
                ph[i] = (ph[i] == 1) ? 2 : 0;
            end else begin
                wt[i]++;
                if (TO[i] > 0 && wt[i] == TO[i]) begin
                    ph[i] = 0; err[i] = 1'b1;
                end
            end
            if (cnt_clr) begin
                hc[i] = 0; mc[i] = 0;
            end
        end
    endtask

    task automatic drive(input logic r, w, h, m, c);
        @(negedge clk);
        en_R = r; en_W = w; hit = h; mem_ready = m; cnt_clr = c;
        #1;
        chk("model_out_a", out_a, mout(0));
        chk("model_hc_a", hc_a, hc[0]);
        chk("model_mc_a", mc_a, mc[0]);
        chk("model_out_b", out_b, mout(1));
        chk("model_hc_b", hc_b, hc[1]);
        chk("model_mc_b", mc_b, mc[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clk();
    endtask

    task automatic add(input logic r, w, h, m, c, input logic [5:0] o, input int ehc, emc);
        vec_t v;
        v.r = r; v.w = w; v.h = h; v.m = m; v.c = c; v.o = o; v.hc = ehc; v.mc = emc;
        tab.push_back(v);
    endtask

    initial begin
        // expected outputs of instance a, o = {Read_mem, Write_mem, enables, sel, stall, mem_err}
        add(0,0,0,0,0, 6'b000000, 0, 0);
        for (int k = 0; k < 3; k++) add(1,0,1,0,0, 6'b000000, k, 0);
        add(1,0,0,0,0, 6'b100010, 3, 0);
        for (int k = 0; k < 3; k++) add(1,0,0,0,0, 6'b100010, 3, 1);
        add(1,0,0,1,0, 6'b100010, 3, 1);
        add(1,0,0,0,0, 6'b101010, 3, 1);
        add(1,0,1,0,0, 6'b000000, 3, 1);
        add(0,1,1,0,0, 6'b011110, 4, 1);
        add(0,1,1,0,0, 6'b010010, 5, 1);
        add(0,1,1,1,0, 6'b010000, 5, 1);
        add(0,1,0,1,0, 6'b011100, 5, 1);
        add(0,0,0,0,0, 6'b000000, 5, 2);
        add(1,1,0,0,0, 6'b100010, 5, 2);
        add(1,1,0,1,0, 6'b100010, 5, 3);
        add(1,1,0,0,0, 6'b101010, 5, 3);
        add(1,1,1,0,0, 6'b000000, 5, 3);
        add(1,0,0,0,0, 6'b100010, 6, 3);
        for (int k = 0; k < 8; k++) add(1,0,0,0,0, 6'b100010, 6, 4);
        add(0,0,0,0,0, 6'b000001, 6, 4);
        add(1,0,1,0,1, 6'b000001, 6, 4);
        add(0,0,0,0,0, 6'b000001, 0, 0);

        model_reset();
        repeat (2) @(posedge clk);
        drive(0,0,0,0,0);
        chk("reset_out_a", out_a, 0);
        chk("reset_out_b", out_b, 0);
        rst = 1'b0;
        tick();

        foreach (tab[k]) begin
            drive(tab[k].r, tab[k].w, tab[k].h, tab[k].m, tab[k].c);
            chk($sformatf("tab%0d_out", k), out_a,
                {tab[k].o[5], tab[k].o[4], {3{tab[k].o[3]}}, tab[k].o[2], tab[k].o[1], tab[k].o[0]});
            chk($sformatf("tab%0d_hc", k), hc_a, tab[k].hc);
            chk($sformatf("tab%0d_mc", k), mc_a, tab[k].mc);
            tick();
        end

        // asynchronous reset in the middle of a read wait
        repeat (3) begin
            drive(1,0,0,0,0);
            tick();
        end
        @(negedge clk);
        en_R = 1'b0; rst = 1'b1;
        #1;
        model_reset();
        chk("arst_out_a", out_a, 0);
        chk("arst_cnt_a", {hc_a, mc_a}, 0);
        chk("arst_out_b", out_b, 0);
        chk("arst_cnt_b", {hc_b, mc_b}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (20) begin
            drive(1,0,1,0,0);
            tick();
        end
        drive(0,0,0,0,0);
        chk("sat_hc_a", hc_a, 15);
        chk("sat_hc_b", hc_b, 20);
        tick();
        drive(1,0,1,0,1);
        tick();
        drive(0,0,0,0,0);
        chk("clr_hc_a", hc_a, 0);
        chk("clr_hc_b", hc_b, 0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
